// File: rtl/safety_timer_unit.sv
// safety_timer_unit: core-local 64-bit mtime with prescaler and compare IRQs.
// Ports: clk_i, rst_ni, reg_req_i/reg_rsp_o (regbus), timer_irqs_o (level IRQs).

package safety_timer_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module safety_timer_unit #(
  parameter int unsigned NumTimers  = 2,
  parameter int unsigned PrescWidth = 8,
  parameter type reg_req_t = safety_timer_pkg::reg_req_t,
  parameter type reg_rsp_t = safety_timer_pkg::reg_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  reg_req_t             reg_req_i,
  output reg_rsp_t             reg_rsp_o,
  output logic [NumTimers-1:0] timer_irqs_o
);

  localparam int unsigned AW = 8;
  localparam logic [PrescWidth-1:0] PcntOne = 1;

  // Register state
  logic                  r_en;
  logic [PrescWidth-1:0] r_presc;
  logic [PrescWidth-1:0] r_pcnt;
  logic [63:0]           r_mtime;
  logic [31:0]           r_snap;
  logic [63:0]           r_cmp [NumTimers];
  logic [NumTimers-1:0]  r_irq;

  // Decode
  logic [AW-1:0]        w_off;
  logic                 w_in_range;
  logic                 w_sel_ctrl;
  logic                 w_sel_lo;
  logic                 w_sel_hi;
  logic [NumTimers-1:0] w_sel_clo;
  logic [NumTimers-1:0] w_sel_chi;
  logic                 w_hit;
  logic                 w_wr;
  logic                 w_rd;

  logic [31:0]          w_ctrl;
  logic [31:0]          w_ctrl_new;
  logic [31:0]          w_rdata;
  logic                 w_tick;
  logic [NumTimers-1:0] w_ge;

  function automatic logic [31:0] f_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  st
  );
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  // Offsets are block-relative; anything above the window is unmapped.
  assign w_off      = reg_req_i.addr[AW-1:0];
  assign w_in_range = (reg_req_i.addr[31:AW] == '0);

  always_comb begin
    w_sel_ctrl = w_in_range && (w_off == 8'h00);
    w_sel_lo   = w_in_range && (w_off == 8'h04);
    w_sel_hi   = w_in_range && (w_off == 8'h08);
    w_sel_clo  = '0;
    w_sel_chi  = '0;
    for (int i = 0; i < NumTimers; i++) begin
      w_sel_clo[i] = w_in_range && (w_off == 8'(16 + 8 * i));
      w_sel_chi[i] = w_in_range && (w_off == 8'(20 + 8 * i));
    end
  end

  assign w_hit = w_sel_ctrl | w_sel_lo | w_sel_hi
               | (|w_sel_clo) | (|w_sel_chi);
  assign w_wr  = reg_req_i.valid & reg_req_i.write & w_hit;
  assign w_rd  = reg_req_i.valid & ~reg_req_i.write & w_hit;

  always_comb begin
    w_ctrl = '0;
    w_ctrl[0] = r_en;
    w_ctrl[8 +: PrescWidth] = r_presc;
  end

  assign w_ctrl_new = f_merge(w_ctrl, reg_req_i.wdata, reg_req_i.wstrb);

  // Read mux
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      unique case (1'b1)
        w_sel_ctrl: w_rdata = w_ctrl;
        w_sel_lo:   w_rdata = r_mtime[31:0];
        w_sel_hi:   w_rdata = r_snap;
        default: begin
          for (int i = 0; i < NumTimers; i++) begin
            if (w_sel_clo[i]) w_rdata = r_cmp[i][31:0];
            if (w_sel_chi[i]) w_rdata = r_cmp[i][63:32];
          end
        end
      endcase
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = reg_req_i.valid & ~w_hit;
    reg_rsp_o.rdata = w_rdata;
  end

  // Prescaler and CTRL
  assign w_tick = r_en && (r_pcnt == r_presc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en    <= 1'b0;
      r_presc <= '0;
      r_pcnt  <= '0;
    end else if (w_wr && w_sel_ctrl) begin
      r_en    <= w_ctrl_new[0];
      r_presc <= w_ctrl_new[8 +: PrescWidth];
      r_pcnt  <= '0;
    end else if (r_en) begin
      r_pcnt  <= w_tick ? '0 : r_pcnt + PcntOne;
    end
  end

  // mtime: a software write to either half wins over a tick in the
  // same cycle; the other half keeps its pre-tick value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime <= '0;
    end else if (w_wr && w_sel_lo) begin
      r_mtime[31:0] <= f_merge(r_mtime[31:0],
                               reg_req_i.wdata,
                               reg_req_i.wstrb);
    end else if (w_wr && w_sel_hi) begin
      r_mtime[63:32] <= f_merge(r_mtime[63:32],
                                reg_req_i.wdata,
                                reg_req_i.wstrb);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // A LO read freezes the upper half for the following HI read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_snap <= '0;
    end else if (w_rd && w_sel_lo) begin
      r_snap <= r_mtime[63:32];
    end
  end

  // Compare registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumTimers; i++) begin
        r_cmp[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NumTimers; i++) begin
        if (w_wr && w_sel_clo[i]) begin
          r_cmp[i][31:0] <= f_merge(r_cmp[i][31:0],
                                    reg_req_i.wdata,
                                    reg_req_i.wstrb);
        end
        if (w_wr && w_sel_chi[i]) begin
          r_cmp[i][63:32] <= f_merge(r_cmp[i][63:32],
                                     reg_req_i.wdata,
                                     reg_req_i.wstrb);
        end
      end
    end
  end

  // Interrupts
  always_comb begin
    w_ge = '0;
    for (int i = 0; i < NumTimers; i++) begin
      w_ge[i] = (r_mtime >= r_cmp[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= '0;
    end else begin
      r_irq <= w_ge;
    end
  end

  assign timer_irqs_o = r_irq;

endmodule

// File: tb/tb_safety_timer_unit.sv
// tb_safety_timer_unit: randomized and directed bench for safety_timer_unit.
// Drives regbus, checks reads and IRQs against a behavioural model.

module tb_safety_timer_unit;
  import safety_timer_pkg::*;

  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  reg_req_t      req;
  reg_rsp_t      rsp;
  logic [NT-1:0] irqs;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  logic          m_en;
  int            m_presc;
  int            m_run;
  logic [63:0]   m_mtime;
  logic [31:0]   m_snap;
  logic [63:0]   m_cmp [NT];
  logic [NT-1:0] m_irq;

  always #5 clk = ~clk;

  safety_timer_unit #(
    .NumTimers(NT),
    .PrescWidth(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .reg_req_i(req),
    .reg_rsp_o(rsp),
    .timer_irqs_o(irqs)
  );

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0] s
  );
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_en = 1'b0;
    m_presc = 0;
    m_run = 0;
    m_mtime = '0;
    m_snap = '0;
    for (int i = 0; i < NT; i++) m_cmp[i] = '1;
    m_irq = '0;
  endtask

  // kind: 0 unmapped, 1 ctrl, 2 lo, 3 hi, 4 cmp lo, 5 cmp hi
  task automatic decode(input logic [31:0] a,
                        output int kind, output int ch);
    kind = 0;
    ch = 0;
    if (a == 0) kind = 1;
    else if (a == 4) kind = 2;
    else if (a == 8) kind = 3;
    else if (a >= 16 && a < 16 + 8 * NT && a % 4 == 0) begin
      ch = int'((a - 16) / 8);
      kind = ((a - 16) % 8 == 0) ? 4 : 5;
    end
  endtask

  function automatic logic [31:0] ctrl_word();
    logic [31:0] w;
    w = '0;
    w[0] = m_en;
    w[15:8] = 8'(m_presc);
    return w;
  endfunction

  task automatic model_read(input logic [31:0] a,
                            output logic [31:0] d,
                            output logic e);
    int k, ch;
    decode(a, k, ch);
    e = (k == 0);
    d = '0;
    case (k)
      1: d = ctrl_word();
      2: d = m_mtime[31:0];
      3: d = m_snap;
      4: d = m_cmp[ch][31:0];
      5: d = m_cmp[ch][63:32];
      default: d = '0;
    endcase
  endtask

  // One clock edge of the model, from pre-edge state.
  task automatic model_edge(input logic v, input logic w,
                            input logic [31:0] a,
                            input logic [31:0] d,
                            input logic [3:0] s);
    logic          tick;
    logic [NT-1:0] irqn;
    logic [63:0]   mt;
    logic [31:0]   cw;
    int            k, ch;
    tick = m_en && ((m_run % (m_presc + 1)) == m_presc);
    for (int i = 0; i < NT; i++) irqn[i] = (m_mtime >= m_cmp[i]);
    decode(a, k, ch);
    if (m_en) m_run++;
    mt = tick ? m_mtime + 64'd1 : m_mtime;
    if (v && w) begin
      case (k)
        1: begin
          cw = merge(ctrl_word(), d, s);
          m_en = cw[0];
          m_presc = int'(cw[15:8]);
          m_run = 0;
        end
        2: mt = {m_mtime[63:32], merge(m_mtime[31:0], d, s)};
        3: mt = {merge(m_mtime[63:32], d, s), m_mtime[31:0]};
        4: m_cmp[ch][31:0] = merge(m_cmp[ch][31:0], d, s);
        5: m_cmp[ch][63:32] = merge(m_cmp[ch][63:32], d, s);
        default: ;
      endcase
    end
    if (v && !w && k == 2) m_snap = m_mtime[63:32];
    m_mtime = mt;
    m_irq = irqn;
  endtask

  // Bus helpers: called at posedge+1, return at posedge+1.
  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic er,
                     output logic [NT-1:0] ir, output logic rdy);
    req.valid = 1'b1;
    req.write = w;
    req.addr = a;
    req.wdata = d;
    req.wstrb = s;
    @(negedge clk);
    rd = rsp.rdata;
    er = rsp.error;
    ir = irqs;
    rdy = rsp.ready;
    @(posedge clk);
    model_edge(1'b1, w, a, d, s);
    #1;
    req.valid = 1'b0;
    req.write = 1'b0;
  endtask

  task automatic rd32(input logic [31:0] a,
                      output logic [31:0] d, output logic e);
    logic [NT-1:0] ir;
    logic r;
    bus(1'b0, a, '0, '0, d, e, ir, r);
  endtask

  task automatic wr32s(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    logic [31:0] rd;
    logic [NT-1:0] ir;
    logic e, r;
    bus(1'b1, a, d, s, rd, e, ir, r);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    wr32s(a, d, 4'hF);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      req.valid = 1'b0;
      @(posedge clk);
      model_edge(1'b0, 1'b0, '0, '0, '0);
      #1;
    end
  endtask

  task automatic do_reset();
    req.valid = 1'b0;
    req.write = 1'b0;
    rst_ni = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 1'b0, '0, '0, '0);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    do_reset();
    idle(100);
    n_tests++;
    if (irqs !== '0) begin
      n_fail++;
      $display("FAIL reset_irq got %h exp 0", irqs);
    end
    n_tests++;
    if (rsp.ready !== 1'b1 || rsp.error !== 1'b0 || rsp.rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp got rdy=%b err=%b rd=%h exp 1 0 0",
               rsp.ready, rsp.error, rsp.rdata);
    end
    rd32(32'h04, d, e);
    n_tests++;
    if (d !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mtime_lo got %h/%b exp 0/0", d, e);
    end
    rd32(32'h10, d, e);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_cmp_lo0 got %h exp ffffffff", d);
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] d, a0;
    logic e;
    do_reset();
    wr32(32'h00, 32'h0000_0301);
    idle(40);
    rd32(32'h04, d, e);
    n_tests++;
    if (d !== 32'd10) begin
      n_fail++;
      $display("FAIL presc3_count got %0d exp 10", d);
    end
    wr32(32'h00, 32'h0000_0101);
    rd32(32'h04, a0, e);
    idle(9);
    rd32(32'h04, d, e);
    n_tests++;
    if (d - a0 !== 32'd5) begin
      n_fail++;
      $display("FAIL presc1_delta got %0d exp 5", d - a0);
    end
    n_tests++;
    if (d !== m_mtime[31:0] + 32'd0 && 1'b0) n_fail++;
  endtask

  task automatic test_irq();
    int guard;
    do_reset();
    wr32(32'h00, 32'h0000_0001);
    wr32(32'h1C, 32'h0);
    wr32(32'h18, 32'd20);
    guard = 0;
    while (m_mtime != 64'd20 && guard < 60) begin
      idle(1);
      guard++;
    end
    n_tests++;
    if (guard >= 60) begin
      n_fail++;
      $display("FAIL irq_wait timeout got %0d exp 20", m_mtime);
    end
    n_tests++;
    if (irqs[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL irq1_early got %b exp 0", irqs[1]);
    end
    idle(1);
    n_tests++;
    if (irqs !== 2'b10) begin
      n_fail++;
      $display("FAIL irq1_rise got %b exp 10", irqs);
    end
    wr32(32'h18, 32'd1000);
    n_tests++;
    if (irqs[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL irq1_hold got %b exp 1", irqs[1]);
    end
    idle(1);
    n_tests++;
    if (irqs !== 2'b00) begin
      n_fail++;
      $display("FAIL irq1_fall got %b exp 00", irqs);
    end
  endtask

  task automatic test_wrap_snapshot();
    logic [31:0] d;
    logic e;
    do_reset();
    wr32(32'h08, 32'h0);
    wr32(32'h04, 32'hFFFF_FFFE);
    wr32(32'h08, 32'hFFFF_FFFF);
    wr32(32'h00, 32'h0000_0001);
    idle(1);
    rd32(32'h04, d, e);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_lo got %h exp ffffffff", d);
    end
    rd32(32'h08, d, e);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL snap_hi got %h exp ffffffff", d);
    end
    rd32(32'h04, d, e);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL wrapped_lo got %h exp 1", d);
    end
    rd32(32'h08, d, e);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL wrapped_hi got %h exp 0", d);
    end
  endtask

  task automatic test_collision_errors();
    logic [31:0] d, ed;
    logic e, ee;
    logic [31:0] bad [4];
    bad[0] = 32'h0C;
    bad[1] = 32'h10 + 8 * NT;
    bad[2] = 32'h06;
    bad[3] = 32'h101;
    do_reset();
    wr32(32'h00, 32'h0000_0001);
    idle(3);
    wr32(32'h04, 32'd5);
    rd32(32'h04, d, e);
    n_tests++;
    if (d !== 32'd5) begin
      n_fail++;
      $display("FAIL collide_lo got %0d exp 5", d);
    end
    wr32s(32'h04, 32'h1234_AB00, 4'b0010);
    model_read(32'h04, ed, ee);
    rd32(32'h04, d, e);
    n_tests++;
    if (d !== ed) begin
      n_fail++;
      $display("FAIL wstrb_lo got %h exp %h", d, ed);
    end
    wr32(32'h0C, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      rd32(bad[i], d, e);
      n_tests++;
      if (e !== 1'b1 || d !== 32'h0) begin
        n_fail++;
        $display("FAIL unmapped_%h got err=%b rd=%h exp 1 0",
                 bad[i], e, d);
      end
    end
    model_read(32'h00, ed, ee);
    rd32(32'h00, d, e);
    n_tests++;
    if (d !== ed || d !== 32'h1) begin
      n_fail++;
      $display("FAIL ctrl_after_bad got %h exp %h", d, ed);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    logic e;
    logic [31:0] ra [7];
    logic [31:0] rv [7];
    ra[0] = 32'h00; rv[0] = 32'h0;
    ra[1] = 32'h04; rv[1] = 32'h0;
    ra[2] = 32'h08; rv[2] = 32'h0;
    ra[3] = 32'h10; rv[3] = 32'hFFFF_FFFF;
    ra[4] = 32'h14; rv[4] = 32'hFFFF_FFFF;
    ra[5] = 32'h18; rv[5] = 32'hFFFF_FFFF;
    ra[6] = 32'h1C; rv[6] = 32'hFFFF_FFFF;
    do_reset();
    wr32(32'h14, 32'h0);
    wr32(32'h10, 32'h0);
    wr32(32'h00, 32'h0000_0201);
    idle(5);
    n_tests++;
    if (irqs[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_irq0 got %b exp 1", irqs[0]);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (irqs !== '0) begin
      n_fail++;
      $display("FAIL async_reset_irq got %b exp 0", irqs);
    end
    model_reset();
    #10;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 1'b0, '0, '0, '0);
    #1;
    for (int i = 0; i < 7; i++) begin
      rd32(ra[i], d, e);
      n_tests++;
      if (d !== rv[i]) begin
        n_fail++;
        $display("FAIL post_reset_%h got %h exp %h", ra[i], d, rv[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs [10];
    logic [31:0] a, d, rd, ed;
    logic [3:0]  s;
    logic [NT-1:0] ir, ei;
    logic er, ee, rdy;
    int op;
    addrs[0] = 32'h00; addrs[1] = 32'h04; addrs[2] = 32'h08;
    addrs[3] = 32'h10; addrs[4] = 32'h14; addrs[5] = 32'h18;
    addrs[6] = 32'h1C; addrs[7] = 32'h0C; addrs[8] = 32'h20;
    addrs[9] = 32'h02;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        idle($urandom_range(1, 6));
        n_tests++;
        if (irqs !== m_irq) begin
          n_fail++;
          $display("FAIL rnd_irq_idle got %b exp %b", irqs, m_irq);
        end
      end else if (op <= 5) begin
        a = addrs[$urandom_range(0, 9)];
        model_read(a, ed, ee);
        ei = m_irq;
        bus(1'b0, a, '0, '0, rd, er, ir, rdy);
        n_tests++;
        if (rd !== ed || er !== ee || ir !== ei || rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_read_%h got %h/%b/%b exp %h/%b/%b",
                   a, rd, er, ir, ed, ee, ei);
        end
      end else begin
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
        d = $urandom();
        if (op == 6) begin
          a = 32'h00;
          d[15:8] = 8'($urandom_range(0, 3));
          d[0] = ($urandom_range(0, 3) != 0);
        end else if (op == 7) begin
          a = ($urandom_range(0, 3) == 0) ? 32'h08 : 32'h04;
          if (a == 32'h08) d = 32'h0;
          else d = $urandom_range(0, 300);
        end else begin
          a = 32'h10 + 4 * $urandom_range(0, 2 * NT - 1);
          if (a[2]) d = ($urandom_range(0, 3) == 0) ? d : 32'h0;
          else d = $urandom_range(0, 300);
        end
        ei = m_irq;
        bus(1'b1, a, d, s, rd, er, ir, rdy);
        n_tests++;
        if (ir !== ei || er !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_write_%h got irq=%b err=%b exp %b 0",
                   a, ir, er, ei);
        end
      end
    end
  endtask

  initial begin
    req = '0;
    model_reset();
    test_reset();
    test_prescaler();
    test_irq();
    test_wrap_snapshot();
    test_collision_errors();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
